sram_access_ctrl: RTL and testbench

//  Multi-cycle controller that serves the MEM stage's 32-bit load/store over a 16-bit external SRAM.

---
 rtl/sram_access_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// sram_access_ctrl : 32-bit load/store over a 16-bit SRAM in two timed phases
// Revision 1.0
// ============================================================================
module sram_access_ctrl #(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdEn,
    input  logic              wrEn,
    input  logic [31:0]       address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    localparam int CNT_W  = $clog2(WAIT_CYCLES);
    localparam int WORD_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               cmd_wr;
    logic               req;
    logic               last;
    logic [WORD_W-1:0]  word_idx;

    assign req      = rdEn | wrEn;
    assign last     = (cnt == CNT_W'(WAIT_CYCLES - 1));
    assign word_idx = WORD_W'((address - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_wr   <= 1'b0;
            readData <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                cmd_wr <= wrEn;
            end
            // Each half is captured on the final cycle of its phase, after the full wait.
            if (!cmd_wr && last) begin
                if (state == LOW) begin
                    readData[15:0] <= sram_dq_in;
                end
                if (state == HIGH) begin
                    readData[31:16] <= sram_dq_in;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end
            end
            LOW: begin
                sram_addr = {word_idx, 1'b0};
                if (cmd_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = writeData[15:0];
                    // Strobe released on the last cycle so address/data hold past it.
                    sram_we_n   = last;
                end
                if (last) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                sram_addr = {word_idx, 1'b1};
                if (cmd_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = writeData[31:16];
                    sram_we_n   = last;
                end
                if (last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sram_access_ctrl : directed bench with a timeline model and SRAM model
// Revision 1.0
// ============================================================================
module tb_sram_access_ctrl;

    localparam int W    = 5;
    localparam int BASE = 1024;
    localparam int AW   = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdEn = 1'b0;
    logic        wrEn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    logic [AW-1:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    sram_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn),
        .address(address), .writeData(writeData), .readData(readData),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // External SRAM: asynchronous read, write on each clock edge the strobe is low.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    logic [15:0] exp_mem  [0:(1<<AW)-1];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Access timeline model: m_t = cycles since the request cycle.
    bit          m_busy = 1'b0;
    int          m_t = 0;
    bit          m_wr = 1'b0;
    logic [AW-2:0] m_w = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_rd = '0;
    logic [31:0] m_off;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_rd   = '0;
        end else if (!m_busy) begin
            if (rdEn || wrEn) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_wr   = wrEn;
                m_off  = (address - 32'(BASE)) / 4;
                m_w    = m_off[AW-2:0];
                m_wd   = writeData;
            end
        end else begin
            if (m_wr && m_t == 1)     exp_mem[{m_w, 1'b0}] = m_wd[15:0];
            if (m_wr && m_t == W + 1) exp_mem[{m_w, 1'b1}] = m_wd[31:16];
            if (!m_wr && m_t == W)     m_rd[15:0]  = exp_mem[{m_w, 1'b0}];
            if (!m_wr && m_t == 2 * W) m_rd[31:16] = exp_mem[{m_w, 1'b1}];
            if (m_t == 2 * W + 1) m_busy = 1'b0;
            else m_t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit lo, hi, dn, e_ready, e_oe, e_we_n;
            int k;
            lo = m_busy && m_t >= 1 && m_t <= W;
            hi = m_busy && m_t > W && m_t <= 2 * W;
            dn = m_busy && m_t == 2 * W + 1;
            e_ready = m_busy ? dn : !(rdEn || wrEn);
            e_oe    = m_wr && (lo || hi);
            k       = lo ? m_t - 1 : m_t - W - 1;
            e_we_n  = !(e_oe && k < W - 1);
            check("ready", 32'(ready), 32'(e_ready));
            check("dq_oe", 32'(sram_dq_oe), 32'(e_oe));
            check("we_n", 32'(sram_we_n), 32'(e_we_n));
            check("readData", readData, m_rd);
            if (lo || hi) check("sram_addr", 32'(sram_addr), 32'({m_w, hi}));
            if (e_oe) check("dq_out", 32'(sram_dq_out), hi ? 32'(m_wd[31:16]) : 32'(m_wd[15:0]));
        end
    end

    // Caller is just after a rising edge; the request cycle starts now.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int wen);
        bit done;
        done    = 1'b0;
        lat     = 0;
        wen     = 0;
        rdEn    = rd;
        wrEn    = wr;
        address = a;
        writeData = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!sram_we_n) wen++;
            if (ready) begin
                done = 1'b1;
                break;
            end
            lat++;
        end
        if (!done) check("ready_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        rdEn = 1'b0;
        wrEn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, wen;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            exp_mem[i]  = '0;
        end
        sram_mem[2] = 16'h1234; exp_mem[2] = 16'h1234;
        sram_mem[3] = 16'hABCD; exp_mem[3] = 16'hABCD;

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_we_n", 32'(sram_we_n), 32'(1));
        check("rst_oe", 32'(sram_dq_oe), 32'(0));
        check("rst_readData", readData, 32'h0);
        check("rst_addr", 32'(sram_addr), 32'(0));
        idle(1);

        // Store
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, wen);
        check("store_latency", 32'(lat), 32'(11));
        check("store_we_cycles", 32'(wen), 32'(8));
        check("store_lo", 32'(sram_mem[0]), 32'h0000BEEF);
        check("store_hi", 32'(sram_mem[1]), 32'h0000DEAD);
        idle(2);

        // Load
        access(1'b1, 1'b0, 32'd1028, 32'h0, lat, wen);
        check("load_latency", 32'(lat), 32'(11));
        check("load_we_cycles", 32'(wen), 32'(0));
        check("load_data", readData, 32'hABCD1234);
        idle(2);

        // Both requests: store wins
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lat, wen);
        check("both_we_cycles", 32'(wen), 32'(8));
        check("both_readData", readData, 32'hABCD1234);
        check("both_lo", 32'(sram_mem[4]), 32'h0000F00D);
        check("both_hi", 32'(sram_mem[5]), 32'h0000CAFE);
        idle(2);

        // Back-to-back load then store
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat, wen);
        check("b2b_load_data", readData, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1040, 32'h55AA33CC, lat, wen);
        check("b2b_store_latency", 32'(lat), 32'(11));
        check("b2b_lo", 32'(sram_mem[8]), 32'h000033CC);
        check("b2b_hi", 32'(sram_mem[9]), 32'h000055AA);
        check("b2b_readData", readData, 32'hDEADBEEF);
        idle(2);

        // Reset during the low phase of a store
        wrEn = 1'b1; address = 32'd1048; writeData = 32'h11112222;
        idle(1);
        idle(1);
        idle(1);
        rst  = 1'b1;
        wrEn = 1'b0;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_we_n", 32'(sram_we_n), 32'(1));
        check("abort_oe", 32'(sram_dq_oe), 32'(0));
        idle(3);
        check("abort_lo", 32'(sram_mem[12]), 32'h00002222);
        check("abort_hi_unwritten", 32'(sram_mem[13]), 32'h0);
        check("abort_readData", readData, 32'h0);

        for (int i = 0; i < 16; i++) check("mem_vs_model", 32'(sram_mem[i]), 32'(exp_mem[i]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
